// File: rtl/spi_sys_bridge.sv
// SPI mode-0 responder that turns CMD/ADDR/DATA frames into single-beat system-bus
// accesses and returns read data on MISO.
module spi_sys_bridge #(
    parameter int TMO  = 255,
    parameter int SYNC = 2
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        spi_cs_i,
    input  logic        spi_clk_i,
    input  logic        spi_mosi_i,
    output logic        spi_miso_o,
    output logic        spi_miso_t,
    output logic [31:0] sys_addr,
    output logic [31:0] sys_wdata,
    output logic        sys_wen,
    output logic        sys_ren,
    input  logic [31:0] sys_rdata,
    input  logic        sys_err,
    input  logic        sys_ack,
    output logic        busy_o,
    output logic        err_o
);

    localparam int TW = $clog2(TMO + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_WDATA,
        ST_TURN,
        ST_RDATA,
        ST_DONE
    } state_t;

    state_t state_reg, state_next;

    logic [SYNC-1:0] cs_sync_reg;
    logic [SYNC-1:0] sck_sync_reg;
    logic [SYNC-1:0] mosi_sync_reg;
    logic            cs_prev_reg;
    logic            sck_prev_reg;
    logic            cs_s;
    logic            sck_s;
    logic            mosi_s;
    logic            cs_fall;
    logic            sck_rise;
    logic            sck_fall;

    logic [6:0]      bit_cnt_reg;
    logic [31:0]     rx_reg;
    logic [31:0]     rx_full;
    logic            cmd_rd_reg;
    logic [31:0]     addr_reg;
    logic [31:0]     tx_reg;
    logic [31:0]     rd_word;
    logic [31:0]     rdata_reg;
    logic            rd_valid_reg;
    logic            acc_rd_reg;
    logic [TW-1:0]   tmo_cnt_reg;

    logic [31:0]     sys_addr_reg;
    logic [31:0]     sys_wdata_reg;
    logic            sys_wen_reg;
    logic            sys_ren_reg;
    logic            busy_reg;
    logic            err_reg;
    logic            miso_reg;
    logic            miso_t_reg;

    logic            cmd_end;
    logic            addr_end;
    logic            wdata_end;
    logic            tx_load;
    logic            tx_shift;
    logic            rd_end;

    assign cs_s     = cs_sync_reg[SYNC-1];
    assign sck_s    = sck_sync_reg[SYNC-1];
    assign mosi_s   = mosi_sync_reg[SYNC-1];
    assign cs_fall  = cs_prev_reg & ~cs_s;
    assign sck_rise = sck_s & ~sck_prev_reg;
    assign sck_fall = ~sck_s & sck_prev_reg;

    // Word including the bit being sampled on this sck_rise.
    assign rx_full  = {rx_reg[30:0], mosi_s};
    assign rd_word  = rd_valid_reg ? rdata_reg : 32'hFFFF_FFFF;

    assign sys_addr   = sys_addr_reg;
    assign sys_wdata  = sys_wdata_reg;
    assign sys_wen    = sys_wen_reg;
    assign sys_ren    = sys_ren_reg;
    assign busy_o     = busy_reg;
    assign err_o      = err_reg;
    assign spi_miso_o = miso_reg;
    assign spi_miso_t = miso_t_reg;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cs_sync_reg   <= '1;
            sck_sync_reg  <= '0;
            mosi_sync_reg <= '0;
        end else begin
            cs_sync_reg[0]   <= spi_cs_i;
            sck_sync_reg[0]  <= spi_clk_i;
            mosi_sync_reg[0] <= spi_mosi_i;
            for (int i = 1; i < SYNC; i++) begin
                cs_sync_reg[i]   <= cs_sync_reg[i-1];
                sck_sync_reg[i]  <= sck_sync_reg[i-1];
                mosi_sync_reg[i] <= mosi_sync_reg[i-1];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cmd_end    = 1'b0;
        addr_end   = 1'b0;
        wdata_end  = 1'b0;
        tx_load    = 1'b0;
        tx_shift   = 1'b0;
        rd_end     = 1'b0;
        if (cs_s) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (cs_fall) state_next = ST_CMD;
                end
                ST_CMD: begin
                    if (sck_rise && bit_cnt_reg == 7'd7) begin
                        cmd_end    = 1'b1;
                        state_next = ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (sck_rise && bit_cnt_reg == 7'd39) begin
                        addr_end   = 1'b1;
                        state_next = cmd_rd_reg ? ST_TURN : ST_WDATA;
                    end
                end
                ST_WDATA: begin
                    if (sck_rise && bit_cnt_reg == 7'd71) begin
                        wdata_end  = 1'b1;
                        state_next = ST_DONE;
                    end
                end
                ST_TURN: begin
                    // The fall ending bit 47 presents the MSB for bit 48.
                    if (sck_fall && bit_cnt_reg == 7'd48) begin
                        tx_load    = 1'b1;
                        state_next = ST_RDATA;
                    end
                end
                ST_RDATA: begin
                    if (sck_fall) begin
                        if (bit_cnt_reg == 7'd80) begin
                            rd_end     = 1'b1;
                            state_next = ST_DONE;
                        end else begin
                            tx_shift = 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state_next = ST_DONE;
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cs_prev_reg   <= 1'b1;
            sck_prev_reg  <= 1'b0;
            bit_cnt_reg   <= '0;
            rx_reg        <= '0;
            cmd_rd_reg    <= 1'b0;
            addr_reg      <= '0;
            tx_reg        <= '0;
            rdata_reg     <= '0;
            rd_valid_reg  <= 1'b0;
            acc_rd_reg    <= 1'b0;
            tmo_cnt_reg   <= '0;
            sys_addr_reg  <= '0;
            sys_wdata_reg <= '0;
            sys_wen_reg   <= 1'b0;
            sys_ren_reg   <= 1'b0;
            busy_reg      <= 1'b0;
            err_reg       <= 1'b0;
            miso_reg      <= 1'b0;
            miso_t_reg    <= 1'b1;
        end else begin
            cs_prev_reg  <= cs_s;
            sck_prev_reg <= sck_s;
            sys_wen_reg  <= 1'b0;
            sys_ren_reg  <= 1'b0;

            if (cs_s) begin
                bit_cnt_reg <= '0;
            end else if (state_reg == ST_IDLE && cs_fall) begin
                bit_cnt_reg <= '0;
            end else if (sck_rise) begin
                bit_cnt_reg <= bit_cnt_reg + 7'd1;
            end

            if (sck_rise && !cs_s) begin
                rx_reg <= rx_full;
            end

            if (cmd_end) begin
                cmd_rd_reg <= rx_full[7];
                if (rx_full[6]) err_reg <= 1'b0;
            end

            // Bus tracking runs regardless of what the frame FSM is doing.
            if (busy_reg) begin
                if (sys_ack || sys_err) begin
                    busy_reg <= 1'b0;
                    if (sys_err) begin
                        err_reg <= 1'b1;
                    end else if (acc_rd_reg) begin
                        rdata_reg    <= sys_rdata;
                        rd_valid_reg <= 1'b1;
                    end
                end else if (tmo_cnt_reg == TW'(TMO - 1)) begin
                    busy_reg <= 1'b0;
                    err_reg  <= 1'b1;
                end else begin
                    tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
                end
            end

            if (addr_end) begin
                addr_reg <= rx_full;
                if (cmd_rd_reg) begin
                    rd_valid_reg <= 1'b0;
                    if (!busy_reg) begin
                        sys_addr_reg <= rx_full;
                        sys_ren_reg  <= 1'b1;
                        busy_reg     <= 1'b1;
                        tmo_cnt_reg  <= '0;
                        acc_rd_reg   <= 1'b1;
                    end else begin
                        err_reg <= 1'b1;
                    end
                end
            end

            if (wdata_end) begin
                if (!busy_reg) begin
                    sys_addr_reg  <= addr_reg;
                    sys_wdata_reg <= rx_full;
                    sys_wen_reg   <= 1'b1;
                    busy_reg      <= 1'b1;
                    tmo_cnt_reg   <= '0;
                    acc_rd_reg    <= 1'b0;
                end else begin
                    err_reg <= 1'b1;
                end
            end

            if (cs_s) begin
                miso_t_reg <= 1'b1;
                miso_reg   <= 1'b0;
            end else if (addr_end && cmd_rd_reg) begin
                miso_t_reg <= 1'b0;
                miso_reg   <= 1'b0;
            end else if (tx_load) begin
                miso_reg <= rd_word[31];
                tx_reg   <= {rd_word[30:0], 1'b0};
                if (!rd_valid_reg) err_reg <= 1'b1;
            end else if (tx_shift) begin
                miso_reg <= tx_reg[31];
                tx_reg   <= {tx_reg[30:0], 1'b0};
            end else if (rd_end) begin
                miso_t_reg <= 1'b1;
                miso_reg   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_sys_bridge.sv
// Directed bench for spi_sys_bridge: SPI controller model plus a bus responder with
// programmable ack latency.
module tb_spi_sys_bridge;

    // Long enough that a full second frame fits inside one outstanding access.
    localparam int TB_TMO = 1000;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic        spi_cs_i;
    logic        spi_clk_i;
    logic        spi_mosi_i;
    logic        spi_miso_o;
    logic        spi_miso_t;
    logic [31:0] sys_addr;
    logic [31:0] sys_wdata;
    logic        sys_wen;
    logic        sys_ren;
    logic [31:0] sys_rdata;
    logic        sys_err;
    logic        sys_ack;
    logic        busy_o;
    logic        err_o;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          resp_delay = -1;
    logic [31:0] resp_data = '0;
    int          pend = 0;
    int          wen_cnt = 0;
    int          ren_cnt = 0;
    logic [31:0] last_addr = '0;
    logic [31:0] last_wdata = '0;
    int          strobe_cyc = 0;
    int          busy_fall_cyc = 0;
    logic        busy_prev = 1'b0;
    logic [79:0] miso_vec;
    logic [79:0] t_vec;

    spi_sys_bridge #(.TMO(TB_TMO), .SYNC(2)) dut (
        .clk_i      (clk_i),
        .rstn_i     (rstn_i),
        .spi_cs_i   (spi_cs_i),
        .spi_clk_i  (spi_clk_i),
        .spi_mosi_i (spi_mosi_i),
        .spi_miso_o (spi_miso_o),
        .spi_miso_t (spi_miso_t),
        .sys_addr   (sys_addr),
        .sys_wdata  (sys_wdata),
        .sys_wen    (sys_wen),
        .sys_ren    (sys_ren),
        .sys_rdata  (sys_rdata),
        .sys_err    (sys_err),
        .sys_ack    (sys_ack),
        .busy_o     (busy_o),
        .err_o      (err_o)
    );

    always #5 clk_i = ~clk_i;

    // Bus responder: acks resp_delay cycles after each strobe (0 = same cycle, <0 = never).
    initial begin
        sys_ack   = 1'b0;
        sys_err   = 1'b0;
        sys_rdata = '0;
        forever begin
            @(negedge clk_i);
            cyc++;
            if (busy_prev && !busy_o) busy_fall_cyc = cyc;
            busy_prev = busy_o;
            sys_ack   = 1'b0;
            sys_rdata = '0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    sys_ack   = 1'b1;
                    sys_rdata = resp_data;
                end
            end
            if (sys_wen || sys_ren) begin
                if (sys_wen) wen_cnt++;
                if (sys_ren) ren_cnt++;
                last_addr  = sys_addr;
                last_wdata = sys_wdata;
                strobe_cyc = cyc;
                if (resp_delay == 0) begin
                    sys_ack   = 1'b1;
                    sys_rdata = resp_data;
                end else if (resp_delay > 0) begin
                    pend = resp_delay;
                end
            end
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    // Mode-0 controller: frame[79-k] is bit k; MISO/tristate captured just before each rise.
    task automatic spi_xfer(input logic [79:0] frame, input int nbits, input int half,
                            input bit keep_cs);
        miso_vec   = '0;
        t_vec      = '1;
        spi_cs_i   = 1'b0;
        wait_clk(half);
        for (int k = 0; k < nbits; k++) begin
            spi_mosi_i = frame[79-k];
            wait_clk(half);
            miso_vec[79-k] = spi_miso_o;
            t_vec[79-k]    = spi_miso_t;
            spi_clk_i      = 1'b1;
            wait_clk(half);
            spi_clk_i      = 1'b0;
        end
        if (!keep_cs) begin
            wait_clk(half);
            spi_cs_i   = 1'b1;
            spi_mosi_i = 1'b0;
            wait_clk(half + 4);
        end
        $display("spi frame: bits=%0d mosi=%h miso=%h", nbits, frame, miso_vec);
    endtask

    task automatic test_reset;
        rstn_i     = 1'b0;
        spi_cs_i   = 1'b1;
        spi_clk_i  = 1'b0;
        spi_mosi_i = 1'b0;
        wait_clk(3);
        checks++; if (spi_miso_t !== 1'b1) begin errors++; $display("FAIL reset_miso_t: got %b expected 1", spi_miso_t); end
        checks++; if (spi_miso_o !== 1'b0) begin errors++; $display("FAIL reset_miso: got %b expected 0", spi_miso_o); end
        checks++; if (sys_wen !== 1'b0 || sys_ren !== 1'b0) begin errors++; $display("FAIL reset_strobes: got wen=%b ren=%b expected 0 0", sys_wen, sys_ren); end
        checks++; if (sys_addr !== 32'h0 || sys_wdata !== 32'h0) begin errors++; $display("FAIL reset_bus: got addr=%h wdata=%h expected 0 0", sys_addr, sys_wdata); end
        checks++; if (busy_o !== 1'b0 || err_o !== 1'b0) begin errors++; $display("FAIL reset_flags: got busy=%b err=%b expected 0 0", busy_o, err_o); end
        rstn_i = 1'b1;
        wait_clk(5);
        checks++; if (spi_miso_t !== 1'b1 || busy_o !== 1'b0) begin errors++; $display("FAIL idle_after_reset: got miso_t=%b busy=%b expected 1 0", spi_miso_t, busy_o); end
    endtask

    task automatic test_write;
        int w0, r0;
        w0 = wen_cnt; r0 = ren_cnt;
        resp_delay = 3;
        spi_xfer({8'h00, 32'h0000_0030, 32'h0000_00A5, 8'h00}, 72, 8, 1'b0);
        wait_clk(10);
        checks++; if (wen_cnt - w0 != 1) begin errors++; $display("FAIL write_wen_count: got %0d expected 1", wen_cnt - w0); end
        checks++; if (ren_cnt != r0) begin errors++; $display("FAIL write_ren_count: got %0d expected 0", ren_cnt - r0); end
        checks++; if (last_addr !== 32'h30) begin errors++; $display("FAIL write_addr: got %h expected 00000030", last_addr); end
        checks++; if (last_wdata !== 32'hA5) begin errors++; $display("FAIL write_wdata: got %h expected 000000a5", last_wdata); end
        checks++; if (busy_fall_cyc - strobe_cyc != 4) begin errors++; $display("FAIL write_busy_len: got %0d expected 4", busy_fall_cyc - strobe_cyc); end
        checks++; if (busy_o !== 1'b0 || err_o !== 1'b0) begin errors++; $display("FAIL write_flags: got busy=%b err=%b expected 0 0", busy_o, err_o); end
    endtask

    task automatic test_read;
        int w0, r0;
        w0 = wen_cnt; r0 = ren_cnt;
        resp_delay = 5;
        resp_data  = 32'h0000_0002;
        spi_xfer({8'h80, 32'h0000_0000, 8'h00, 32'h0}, 80, 8, 1'b0);
        checks++; if (ren_cnt - r0 != 1 || wen_cnt != w0) begin errors++; $display("FAIL read_strobes: got ren=%0d wen=%0d expected 1 0", ren_cnt - r0, wen_cnt - w0); end
        checks++; if (last_addr !== 32'h0) begin errors++; $display("FAIL read_addr: got %h expected 00000000", last_addr); end
        checks++; if (miso_vec[31:0] !== 32'h0000_0002) begin errors++; $display("FAIL read_data: got %h expected 00000002", miso_vec[31:0]); end
        checks++; if (miso_vec[39:32] !== 8'h00) begin errors++; $display("FAIL read_turn_bits: got %h expected 00", miso_vec[39:32]); end
        checks++; if (t_vec !== 80'hFFFF_FFFF_FF00_0000_0000) begin errors++; $display("FAIL read_miso_t: got %h expected ffffffffff0000000000", t_vec); end
        checks++; if (spi_miso_t !== 1'b1 || err_o !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL read_end_flags: got t=%b err=%b busy=%b expected 1 0 0", spi_miso_t, err_o, busy_o); end

        r0 = ren_cnt;
        resp_delay = 0;
        resp_data  = 32'hDEAD_BEEF;
        spi_xfer({8'h80, 32'h1234_5678, 8'h00, 32'h0}, 80, 4, 1'b0);
        checks++; if (ren_cnt - r0 != 1) begin errors++; $display("FAIL read0_ren_count: got %0d expected 1", ren_cnt - r0); end
        checks++; if (miso_vec[31:0] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL read0_data: got %h expected deadbeef", miso_vec[31:0]); end
        checks++; if (busy_fall_cyc - strobe_cyc != 1) begin errors++; $display("FAIL read0_busy_len: got %0d expected 1", busy_fall_cyc - strobe_cyc); end
        checks++; if (sys_addr !== 32'h1234_5678) begin errors++; $display("FAIL read0_addr_hold: got %h expected 12345678", sys_addr); end
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL read0_err: got %b expected 0", err_o); end
    endtask

    task automatic test_timeout;
        int r0, w0;
        resp_delay = -1;
        r0 = ren_cnt;
        spi_xfer({8'h80, 32'h0000_0008, 8'h00, 32'h0}, 80, 4, 1'b0);
        checks++; if (miso_vec[31:0] !== 32'hFFFF_FFFF) begin errors++; $display("FAIL tmo_data: got %h expected ffffffff", miso_vec[31:0]); end
        checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL tmo_err_set: got %b expected 1", err_o); end
        checks++; if (ren_cnt - r0 != 1) begin errors++; $display("FAIL tmo_ren_count: got %0d expected 1", ren_cnt - r0); end
        for (int i = 0; i < TB_TMO + 200 && busy_o; i++) wait_clk(1);
        wait_clk(2);
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL tmo_busy_clear: got %b expected 0", busy_o); end
        checks++; if (busy_fall_cyc - strobe_cyc != TB_TMO) begin errors++; $display("FAIL tmo_len: got %0d expected %0d", busy_fall_cyc - strobe_cyc, TB_TMO); end
        w0 = wen_cnt; r0 = ren_cnt;
        spi_xfer({8'h40, 72'h0}, 8, 4, 1'b0);
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL err_clear_cmd: got %b expected 0", err_o); end
        checks++; if (wen_cnt != w0 || ren_cnt != r0) begin errors++; $display("FAIL short_frame_access: got wen=%0d ren=%0d expected 0 0", wen_cnt - w0, ren_cnt - r0); end
    endtask

    task automatic test_abort;
        int w0, r0;
        w0 = wen_cnt; r0 = ren_cnt;
        resp_delay = 2;
        spi_xfer({8'h00, 32'h0000_0020, 32'h1111_1111, 8'h00}, 20, 4, 1'b0);
        checks++; if (wen_cnt != w0) begin errors++; $display("FAIL abort_no_strobe: got %0d expected 0", wen_cnt - w0); end
        spi_xfer({8'h00, 32'h0000_0010, 32'h0000_00FF, 8'hFF}, 80, 4, 1'b0);
        checks++; if (wen_cnt - w0 != 1 || ren_cnt != r0) begin errors++; $display("FAIL abort_next_strobes: got wen=%0d ren=%0d expected 1 0", wen_cnt - w0, ren_cnt - r0); end
        checks++; if (last_addr !== 32'h10) begin errors++; $display("FAIL abort_next_addr: got %h expected 00000010", last_addr); end
        checks++; if (last_wdata !== 32'hFF) begin errors++; $display("FAIL abort_next_wdata: got %h expected 000000ff", last_wdata); end
        checks++; if (err_o !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL abort_flags: got err=%b busy=%b expected 0 0", err_o, busy_o); end
    endtask

    task automatic test_back_to_back;
        int w0;
        w0 = wen_cnt;
        resp_delay = 800;
        spi_xfer({8'h00, 32'h0000_0020, 32'h0000_0011, 8'h00}, 72, 4, 1'b0);
        spi_xfer({8'h00, 32'h0000_0024, 32'h0000_0022, 8'h00}, 72, 4, 1'b0);
        checks++; if (wen_cnt - w0 != 1) begin errors++; $display("FAIL b2b_wen_count: got %0d expected 1", wen_cnt - w0); end
        checks++; if (err_o !== 1'b1 || busy_o !== 1'b1) begin errors++; $display("FAIL b2b_flags: got err=%b busy=%b expected 1 1", err_o, busy_o); end
        checks++; if (sys_addr !== 32'h20 || sys_wdata !== 32'h11) begin errors++; $display("FAIL b2b_bus_hold: got addr=%h wdata=%h expected 00000020 00000011", sys_addr, sys_wdata); end
        for (int i = 0; i < 600 && busy_o; i++) wait_clk(1);
        wait_clk(2);
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL b2b_busy_clear: got %b expected 0", busy_o); end
        checks++; if (busy_fall_cyc - strobe_cyc != 801) begin errors++; $display("FAIL b2b_ack_len: got %0d expected 801", busy_fall_cyc - strobe_cyc); end
    endtask

    task automatic test_reset_mid_frame;
        int r0;
        resp_delay = 4;
        resp_data  = 32'h5A5A_0F0F;
        spi_xfer({8'h80, 32'h0000_0040, 8'h00, 32'h0}, 61, 4, 1'b1);
        checks++; if (spi_miso_t !== 1'b0) begin errors++; $display("FAIL rdata_driving: got %b expected 0", spi_miso_t); end
        rstn_i = 1'b0;
        #1;
        checks++; if (spi_miso_t !== 1'b1 || spi_miso_o !== 1'b0) begin errors++; $display("FAIL midrst_miso: got t=%b miso=%b expected 1 0", spi_miso_t, spi_miso_o); end
        checks++; if (sys_wen !== 1'b0 || sys_ren !== 1'b0) begin errors++; $display("FAIL midrst_strobes: got wen=%b ren=%b expected 0 0", sys_wen, sys_ren); end
        checks++; if (err_o !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL midrst_flags: got err=%b busy=%b expected 0 0", err_o, busy_o); end
        checks++; if (sys_addr !== 32'h0 || sys_wdata !== 32'h0) begin errors++; $display("FAIL midrst_bus: got addr=%h wdata=%h expected 0 0", sys_addr, sys_wdata); end
        spi_cs_i   = 1'b1;
        spi_clk_i  = 1'b0;
        spi_mosi_i = 1'b0;
        wait_clk(4);
        rstn_i = 1'b1;
        wait_clk(4);
        r0 = ren_cnt;
        resp_delay = 2;
        resp_data  = 32'hCAFE_F00D;
        spi_xfer({8'h80, 32'h0000_0044, 8'h00, 32'h0}, 80, 4, 1'b0);
        checks++; if (ren_cnt - r0 != 1 || last_addr !== 32'h44) begin errors++; $display("FAIL post_rst_read_strobe: got ren=%0d addr=%h expected 1 00000044", ren_cnt - r0, last_addr); end
        checks++; if (miso_vec[31:0] !== 32'hCAFE_F00D) begin errors++; $display("FAIL post_rst_read_data: got %h expected cafef00d", miso_vec[31:0]); end
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL post_rst_err: got %b expected 0", err_o); end
    endtask

    initial begin
        test_reset;
        test_write;
        test_read;
        test_timeout;
        test_abort;
        test_back_to_back;
        test_reset_mid_frame;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
